// File: rtl/iir_pkg.sv
// Shared helpers for the shift-and-add IIR filter: accumulator sizing,
// output saturation and tap sign encoding.
package iir_pkg;

  localparam logic SIGN_ADD = 1'b0;
  localparam logic SIGN_SUB = 1'b1;

  // Guard bits cover NX_TAPS feed-forward terms plus two feedback terms.
  function automatic int nb_acc(input int nb_data, input int nx_taps);
    return nb_data + $clog2(nx_taps + 2) + 1;
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int nb);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nb - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_sat_shift.sv
// Arithmetic right shift of a feedback sample; oversize shifts collapse
// to the sign (0 or -1), and a disabled term contributes 0.
module iir_sat_shift #(
  parameter int NB_DATA  = 16,
  parameter int NB_SHIFT = 4
) (
  input  logic [NB_DATA-1:0]  y,
  input  logic [NB_SHIFT-1:0] shift,
  input  logic                en,
  output logic [NB_DATA-1:0]  y_sh
);

  always_comb begin
    y_sh = '0;
    if (en) begin
      if (32'(shift) >= NB_DATA) y_sh = {NB_DATA{y[NB_DATA-1]}};
      else                       y_sh = $signed(y) >>> shift;
    end
  end

endmodule

// File: rtl/iir_shift_add_filter.sv
// Signed shift-and-add IIR: signed feed-forward taps plus two shifted
// feedback terms, saturated output with sticky overflow flag.
module iir_shift_add_filter
  import iir_pkg::*;
#(
  parameter int NB_DATA  = 16,
  parameter int NX_TAPS  = 4,
  parameter int NB_SHIFT = 4
) (
  input  logic                clock,
  input  logic                i_rst_n,
  input  logic [NB_DATA-1:0]  i_x,
  input  logic                i_valid,
  input  logic [NX_TAPS-1:0]  i_ff_sign,
  input  logic [NB_SHIFT-1:0] i_fb1_shift,
  input  logic [NB_SHIFT-1:0] i_fb2_shift,
  input  logic [1:0]          i_fb_en,
  input  logic                i_bypass,
  input  logic                i_clear,
  input  logic                i_sat_clr,
  output logic [NB_DATA-1:0]  o_y,
  output logic                o_valid,
  output logic                o_sat
);

  localparam int NB_ACC = nb_acc(NB_DATA, NX_TAPS);

  logic [NX_TAPS-2:0][NB_DATA-1:0] x_hist;
  logic [NX_TAPS-1:0][NB_DATA-1:0] x_taps;
  logic [NB_DATA-1:0]              y2;
  logic [1:0][NB_DATA-1:0]         fb_src, fb_term;
  logic [1:0][NB_SHIFT-1:0]        fb_shift;

  logic signed [NB_ACC-1:0] acc, term;
  logic signed [63:0]       acc_ext, sat_wide;
  logic [NB_DATA-1:0]       y_sat, y_new;
  logic                     clamp;

  assign x_taps[0] = i_x;
  genvar k;
  generate
    for (k = 1; k < NX_TAPS; k++) begin : g_tap
      assign x_taps[k] = x_hist[k-1];
    end
  endgenerate

  // o_y is always the stored y[n-1]; only y[n-2] needs its own register.
  assign fb_src[0]   = o_y;
  assign fb_src[1]   = y2;
  assign fb_shift[0] = i_fb1_shift;
  assign fb_shift[1] = i_fb2_shift;

  generate
    for (k = 0; k < 2; k++) begin : g_fb
      iir_sat_shift #(.NB_DATA(NB_DATA), .NB_SHIFT(NB_SHIFT)) u_sh (
        .y     (fb_src[k]),
        .shift (fb_shift[k]),
        .en    (i_fb_en[k]),
        .y_sh  (fb_term[k])
      );
    end
  endgenerate

  always_comb begin
    acc  = '0;
    term = '0;
    for (int t = 0; t < NX_TAPS; t++) begin
      term = NB_ACC'($signed(x_taps[t]));
      acc  = (i_ff_sign[t] == SIGN_SUB) ? acc - term : acc + term;
    end
    for (int j = 0; j < 2; j++) acc = acc + NB_ACC'($signed(fb_term[j]));
  end

  assign acc_ext  = 64'(acc);
  assign sat_wide = sat_to(acc_ext, NB_DATA);
  assign y_sat    = NB_DATA'(sat_wide);
  assign clamp    = (sat_wide != acc_ext);
  assign y_new    = i_bypass ? i_x : y_sat;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_hist  <= '0;
      y2      <= '0;
      o_y     <= '0;
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_sat_clr) o_sat <= 1'b0;
      if (i_clear) begin
        x_hist <= '0;
        y2     <= '0;
        o_y    <= '0;
      end else if (i_valid) begin
        x_hist[0] <= i_x;
        for (int t = 1; t < NX_TAPS-1; t++) x_hist[t] <= x_hist[t-1];
        y2      <= o_y;
        o_y     <= y_new;
        o_valid <= 1'b1;
        // A new overflow wins over a same-cycle sat clear.
        if (!i_bypass && clamp) o_sat <= 1'b1;
      end
    end
  end

endmodule
